// File: rtl/tlp_framer.sv
// TLP framer: wraps each accepted TLP in STP/END K-symbols and streams it out
// one byte per cycle, LSB byte first, with back-to-back frames accepted in EOF.
module tlp_framer #(
  parameter int unsigned TLP_BYTES = 20,
  parameter logic [7:0]  STP_SYM   = 8'hFB,
  parameter logic [7:0]  END_SYM   = 8'hFD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tlp_valid,
  input  logic [8*TLP_BYTES-1:0] tlp_data,
  output logic                   tlp_ready,
  output logic [7:0]             data_out,
  output logic                   datak,
  output logic                   busy,
  output logic [7:0]             TLP_count
);

  localparam int unsigned   IdxW    = (TLP_BYTES > 1) ? $clog2(TLP_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(TLP_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StSof, StPayload, StEof} state_e;

  state_e                   state_q;
  logic [IdxW-1:0]          idx_q;
  logic [IdxW-1:0]          idx_next;
  logic [8*TLP_BYTES-1:0]   hold_q;
  logic [7:0]               next_byte;
  logic                     accept;

  assign tlp_ready = !reset && ((state_q == StIdle) || (state_q == StEof));
  assign accept    = tlp_valid && tlp_ready;
  assign idx_next  = idx_q + 1'b1;
  // Only consumed while idx_q < LastIdx, so idx_next is always in range when used.
  assign next_byte = hold_q[8*int'(idx_next) +: 8];

  // Outputs are loaded with the value belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      hold_q    <= '0;
      data_out  <= 8'h00;
      datak     <= 1'b0;
      busy      <= 1'b0;
      TLP_count <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle, StEof: begin
          if (state_q == StEof) TLP_count <= TLP_count + 8'd1;
          if (accept) begin
            hold_q   <= tlp_data;
            state_q  <= StSof;
            data_out <= STP_SYM;
            datak    <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state_q  <= StIdle;
            data_out <= 8'h00;
            datak    <= 1'b0;
            busy     <= 1'b0;
          end
        end
        StSof: begin
          state_q  <= StPayload;
          idx_q    <= '0;
          data_out <= hold_q[7:0];
          datak    <= 1'b0;
        end
        StPayload: begin
          if (idx_q == LastIdx) begin
            state_q  <= StEof;
            data_out <= END_SYM;
            datak    <= 1'b1;
          end else begin
            idx_q    <= idx_next;
            data_out <= next_byte;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_framer.sv
// Bench for tlp_framer: a symbol-queue reference model predicts the output stream,
// ready, busy and frame count every cycle under directed and random stimulus.
module tb_tlp_framer;

  localparam int TB = 20;
  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] ENDS = 8'hFD;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tlp_valid = 1'b0;
  logic [8*TB-1:0] tlp_data = '0;
  logic            tlp_ready;
  logic [7:0]      data_out;
  logic            datak;
  logic            busy;
  logic [7:0]      TLP_count;

  tlp_framer #(.TLP_BYTES(TB), .STP_SYM(STP), .END_SYM(ENDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .tlp_valid (tlp_valid),
    .tlp_data  (tlp_data),
    .tlp_ready (tlp_ready),
    .data_out  (data_out),
    .datak     (datak),
    .busy      (busy),
    .TLP_count (TLP_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic k;} sym_t;

  sym_t       exp_q[$];
  sym_t       cur = '{8'h00, 1'b0};
  bit         cur_busy = 1'b0;
  logic [7:0] cnt_m = 8'h00;
  int         vectors = 0;
  int         miscompares = 0;
  int         busy_cycles;
  logic [8*TB-1:0] pat;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8*TB-1:0] rand_tlp();
    logic [8*TB-1:0] r;
    for (int i = 0; i < TB; i++) r[8*i +: 8] = 8'($urandom);
    return r;
  endfunction

  // One clock: drive inputs, check ready, advance the model at the edge, check outputs.
  task automatic tick(input logic v, input logic [8*TB-1:0] d, input logic r);
    bit rdy;
    bit acc;
    @(negedge clk);
    tlp_valid = v;
    tlp_data  = d;
    reset     = r;
    #1;
    rdy = !r && (exp_q.size() == 0);
    chk("tlp_ready", {7'd0, tlp_ready}, {7'd0, rdy});
    acc = v && rdy;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      cur      = '{8'h00, 1'b0};
      cur_busy = 1'b0;
      cnt_m    = 8'h00;
    end else begin
      if (cur_busy && cur.k && cur.d == ENDS) cnt_m = cnt_m + 8'd1;
      if (acc) begin
        exp_q.push_back('{STP, 1'b1});
        for (int i = 0; i < TB; i++) exp_q.push_back('{d[8*i +: 8], 1'b0});
        exp_q.push_back('{ENDS, 1'b1});
      end
      if (exp_q.size() > 0) begin
        cur      = exp_q.pop_front();
        cur_busy = 1'b1;
      end else begin
        cur      = '{8'h00, 1'b0};
        cur_busy = 1'b0;
      end
    end
    #1;
    chk("data_out", data_out, cur.d);
    chk("datak", {7'd0, datak}, {7'd0, cur.k});
    chk("busy", {7'd0, busy}, {7'd0, cur_busy});
    chk("TLP_count", TLP_count, cnt_m);
    if (busy) busy_cycles++;
  endtask

  initial begin
    // Reset with valid asserted: must not be accepted.
    tick(1'b1, rand_tlp(), 1'b1);
    tick(1'b0, '0, 1'b1);

    // Single frame, byte k = k+1.
    for (int i = 0; i < TB; i++) pat[8*i +: 8] = 8'(i + 1);
    busy_cycles = 0;
    tick(1'b1, pat, 1'b0);
    for (int i = 0; i < 26; i++) tick(1'b0, rand_tlp(), 1'b0);
    chk("single_busy_cycles", 8'(busy_cycles), 8'd22);
    chk("single_count", TLP_count, 8'd1);

    // Back-to-back with data churning every cycle while valid stays high.
    tick(1'b0, '0, 1'b1);
    busy_cycles = 0;
    for (int i = 0; i < 2 * (TB + 2); i++) tick(1'b1, rand_tlp(), 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0);
    chk("b2b_busy_cycles", 8'(busy_cycles), 8'd44);
    chk("b2b_count", TLP_count, 8'd2);

    // Mid-frame reset while payload byte 7 is on the wire.
    tick(1'b0, '0, 1'b1);
    tick(1'b1, rand_tlp(), 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b1, rand_tlp(), 1'b0);
    chk("byte7_shown", data_out, cur.d);
    tick(1'b1, rand_tlp(), 1'b1);
    chk("abort_count", TLP_count, 8'd0);
    tick(1'b1, rand_tlp(), 1'b0);
    for (int i = 0; i < TB + 4; i++) tick(1'b0, rand_tlp(), 1'b0);
    chk("after_abort_count", TLP_count, 8'd1);

    // Random valid/data traffic.
    for (int i = 0; i < 400; i++) tick(1'($urandom_range(0, 1)), rand_tlp(), 1'b0);
    for (int i = 0; i < TB + 3; i++) tick(1'b0, '0, 1'b0);

    // Counter wrap over 256 back-to-back frames.
    tick(1'b0, '0, 1'b1);
    for (int f = 0; f < 256; f++) begin
      for (int c = 0; c < TB + 2; c++) tick(1'b1, rand_tlp(), 1'b0);
      if (f == 254) begin
        tick(1'b0, '0, 1'b0);
        chk("count_255", TLP_count, 8'd255);
        tick(1'b0, '0, 1'b0);
      end
    end
    tick(1'b0, '0, 1'b0);
    chk("count_wrap", TLP_count, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
